cnn_layer_accel_cascade_ctrl: RTL and testbench

- Parametrised cascade interconnect and synchronisation barrier for a chain of C_NUM_QUADS cnn_layer_accel_quad instances.
- Places a first-word-fall-through link FIFO between each quad's cascade output and the next quad's cascade input, with true backpressure via cascade_out_ready.
- Sources the head of the chain and exposes the tail.
- Produces masked, registered, sticky AND-reductions of pip_primed and pfb_loaded, returned to the quads as all_pip_primed and all_pfb_loaded.

---
 rtl/cnn_layer_accel_cascade_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_cnn_layer_accel_cascade_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_cascade_ctrl.sv
// Cascade interconnect and sync barrier for a chain of cnn_layer_accel_quad
// instances. One FWFT link FIFO sits between each quad's cascade output and
// the next quad's cascade input; the chain head and tail pass straight
// through. Two sticky, masked AND-barriers gather pip_primed / pfb_loaded.

// One link FIFO: first-word-fall-through, registered level, no bypass path.
module cnn_layer_accel_cascade_link #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk_core,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [DW-1:0]              push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  input  logic                       pop_ready,
  output logic [DW-1:0]              pop_data,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  // Ready/valid come only from the registered level, so a word pushed into
  // an empty link shows up downstream on the following cycle.
  assign push_ready = (level_q < LW'(DEPTH));
  assign pop_valid  = (level_q != '0);
  assign pop_data   = mem[rd_ptr_q];
  assign level      = level_q;

  assign push = push_valid & push_ready;
  assign pop  = pop_valid & pop_ready;

  // Next-state for pointers and level; flush discards any same-cycle traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level state.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk_core) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end
endmodule

module cnn_layer_accel_cascade_ctrl #(
  parameter int C_NUM_QUADS  = 4,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_FIFO_DEPTH = 8
) (
  input  logic                                              clk_core,
  input  logic                                              rst,
  input  logic                                              flush,
  input  logic                                              head_valid,
  input  logic [C_DATA_WIDTH-1:0]                           head_data,
  output logic                                              head_ready,
  input  logic [C_NUM_QUADS-1:0]                            cascade_out_valid,
  output logic [C_NUM_QUADS-1:0]                            cascade_out_ready,
  input  logic [C_NUM_QUADS*C_DATA_WIDTH-1:0]               cascade_out_data,
  output logic [C_NUM_QUADS-1:0]                            cascade_in_valid,
  input  logic [C_NUM_QUADS-1:0]                            cascade_in_ready,
  output logic [C_NUM_QUADS*C_DATA_WIDTH-1:0]               cascade_in_data,
  output logic                                              tail_valid,
  input  logic                                              tail_ready,
  output logic [C_DATA_WIDTH-1:0]                           tail_data,
  input  logic [C_NUM_QUADS-1:0]                            quad_enable,
  input  logic [C_NUM_QUADS-1:0]                            pip_primed,
  input  logic [C_NUM_QUADS-1:0]                            pfb_loaded,
  input  logic                                              barrier_clear,
  output logic                                              all_pip_primed,
  output logic                                              all_pfb_loaded,
  output logic [(C_NUM_QUADS-1)*($clog2(C_FIFO_DEPTH)+1)-1:0] link_level
);
  localparam int N  = C_NUM_QUADS;
  localparam int DW = C_DATA_WIDTH;
  localparam int LW = $clog2(C_FIFO_DEPTH) + 1;

  logic [N-1:0][DW-1:0] out_data_a;
  logic [N-1:0][DW-1:0] in_data_a;
  logic [N-1:0]         in_valid_a;
  logic [N-1:0]         out_ready_a;
  logic [N-2:0][LW-1:0] level_a;

  assign out_data_a        = cascade_out_data;
  assign cascade_in_data   = in_data_a;
  assign cascade_in_valid  = in_valid_a;
  assign cascade_out_ready = out_ready_a;
  assign link_level        = level_a;

  // Chain head feeds quad 0 directly; tail exposes the last quad directly.
  assign in_valid_a[0]  = head_valid;
  assign in_data_a[0]   = head_data;
  assign head_ready     = cascade_in_ready[0];
  assign tail_valid     = cascade_out_valid[N-1];
  assign tail_data      = out_data_a[N-1];
  assign out_ready_a[N-1] = tail_ready;

  for (genvar i = 0; i < N-1; i++) begin : g_link
    cnn_layer_accel_cascade_link #(
      .DW    (DW),
      .DEPTH (C_FIFO_DEPTH)
    ) u_link (
      .clk_core   (clk_core),
      .rst        (rst),
      .flush      (flush),
      .push_valid (cascade_out_valid[i]),
      .push_data  (out_data_a[i]),
      .push_ready (out_ready_a[i]),
      .pop_valid  (in_valid_a[i+1]),
      .pop_ready  (cascade_in_ready[i+1]),
      .pop_data   (in_data_a[i+1]),
      .level      (level_a[i])
    );
  end

  // Disabled quads are treated as done; an empty mask never satisfies.
  logic raw_pip, raw_pfb;
  logic all_pip_q, all_pip_d;
  logic all_pfb_q, all_pfb_d;

  assign raw_pip = (&(pip_primed | ~quad_enable)) & (|quad_enable);
  assign raw_pfb = (&(pfb_loaded | ~quad_enable)) & (|quad_enable);

  // Sticky set, clear has priority over a same-cycle set.
  always_comb begin
    all_pip_d = all_pip_q | raw_pip;
    all_pfb_d = all_pfb_q | raw_pfb;
    if (barrier_clear) begin
      all_pip_d = 1'b0;
      all_pfb_d = 1'b0;
    end
  end

  // Barrier output registers.
  always_ff @(posedge clk_core or negedge rst) begin
    if (!rst) begin
      all_pip_q <= 1'b0;
      all_pfb_q <= 1'b0;
    end else begin
      all_pip_q <= all_pip_d;
      all_pfb_q <= all_pfb_d;
    end
  end

  assign all_pip_primed = all_pip_q;
  assign all_pfb_loaded = all_pfb_q;
endmodule

// File: tb/tb_cnn_layer_accel_cascade_ctrl.sv
// Directed bench with a scoreboard on the quad 1 cascade input.
module tb_cnn_layer_accel_cascade_ctrl;
  logic        clk = 1'b0;
  logic        rst, flush, head_valid, head_ready;
  logic [15:0] head_data;
  logic [3:0]  cov, cor, civ, cir;
  logic [63:0] cod, cid;
  logic        tail_valid, tail_ready;
  logic [15:0] tail_data;
  logic [3:0]  quad_enable, pip, pfb;
  logic        barrier_clear, all_pip, all_pfb;
  logic [11:0] link_level;

  int          n_vec = 0;
  int          n_err = 0;
  int          maxl  = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  cnn_layer_accel_cascade_ctrl #(
    .C_NUM_QUADS(4), .C_DATA_WIDTH(16), .C_FIFO_DEPTH(8)
  ) dut (
    .clk_core          (clk),
    .rst               (rst),
    .flush             (flush),
    .head_valid        (head_valid),
    .head_data         (head_data),
    .head_ready        (head_ready),
    .cascade_out_valid (cov),
    .cascade_out_ready (cor),
    .cascade_out_data  (cod),
    .cascade_in_valid  (civ),
    .cascade_in_ready  (cir),
    .cascade_in_data   (cid),
    .tail_valid        (tail_valid),
    .tail_ready        (tail_ready),
    .tail_data         (tail_data),
    .quad_enable       (quad_enable),
    .pip_primed        (pip),
    .pfb_loaded        (pfb),
    .barrier_clear     (barrier_clear),
    .all_pip_primed    (all_pip),
    .all_pfb_loaded    (all_pfb),
    .link_level        (link_level)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word from quad 0; record it as expected once it is accepted.
  task automatic send(input logic [15:0] w);
    int  t;
    bit  ok;
    t  = 0;
    ok = 1'b0;
    cod[15:0] = w;
    cov[0]    = 1'b1;
    forever begin
      @(negedge clk);
      if (cor[0]) begin ok = 1'b1; break; end
      t++;
      if (t > 100) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: word %0h never accepted", w);
        break;
      end
    end
    if (ok) exp_q.push_back(w);
    @(posedge clk);
    #1;
    cov[0] = 1'b0;
    if (int'(link_level[3:0]) > maxl) maxl = int'(link_level[3:0]);
  endtask

  // Monitor: every transfer into quad 1 must match the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1 && civ[1] && cir[1]) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL q1_unexpected: got %0h expected none", cid[31:16]);
      end else begin
        check("q1_data", {16'h0, cid[31:16]}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; flush = 1'b0; head_valid = 1'b0; head_data = '0;
    cov = '0; cod = '0; cir = 4'b1111; tail_ready = 1'b0;
    quad_enable = '0; pip = '0; pfb = '0; barrier_clear = 1'b0;

    // Reset state and pass-through paths while in reset
    #3;
    check("rst_level", link_level, 0);
    check("rst_civ", civ, 0);
    check("rst_barrier", {all_pip, all_pfb}, 0);
    check("rst_cor_tail0", cor, 4'b0111);
    tail_ready = 1'b1; head_valid = 1'b1; head_data = 16'hABCD;
    cov[3] = 1'b1; cod[63:48] = 16'h1234;
    #1;
    check("rst_cor", cor, 4'b1111);
    check("head_pass", {civ[0], head_ready, cid[15:0]}, {2'b11, 16'hABCD});
    check("tail_pass", {tail_valid, tail_data}, {1'b1, 16'h1234});
    head_valid = 1'b0; cov[3] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Streaming 1..20 with downstream always ready
    send(16'd1);
    check("latency_civ1", civ[1], 1);
    for (int w = 2; w <= 20; w++) send(16'(w));
    repeat (3) tick();
    check("stream_drained", exp_q.size(), 0);
    check("stream_maxlevel", maxl, 1);

    // Backpressure: quad 1 stalls, link fills to 8
    cir[1] = 1'b0;
    for (int w = 101; w <= 108; w++) send(16'(w));
    check("bp_level8", link_level[3:0], 8);
    check("bp_ready0", cor[0], 0);
    fork
      begin send(16'd109); send(16'd110); end
      begin
        repeat (3) tick();
        check("bp_hold8", link_level[3:0], 8);
        cir[1] = 1'b1;
      end
    join
    repeat (12) tick();
    check("bp_drained", exp_q.size(), 0);
    check("bp_level0", link_level[3:0], 0);

    // Full boundary: pop and offered push in the same cycle
    cir[1] = 1'b0;
    for (int w = 201; w <= 208; w++) send(16'(w));
    cov[0] = 1'b1; cod[15:0] = 16'd209; cir[1] = 1'b1;
    check("full_refuse", cor[0], 0);
    tick();
    check("full_level7", link_level[3:0], 7);
    cir[1] = 1'b0;
    check("full_ready1", cor[0], 1);
    exp_q.push_back(16'd209);
    tick();
    check("full_level8", link_level[3:0], 8);
    cov[0] = 1'b0; cir[1] = 1'b1;
    repeat (10) tick();
    check("full_drained", exp_q.size(), 0);

    // Barrier with quad 2 masked off
    quad_enable = 4'b1011;
    for (int c = 0; c <= 22; c++) begin
      if (c == 5)  pip[0] = 1'b1;
      if (c == 9)  pip[1] = 1'b1;
      if (c == 12) pip[3] = 1'b1;
      if (c == 15) pip = '0;
      barrier_clear = (c == 20);
      check($sformatf("bar_c%0d", c), all_pip, (c >= 13 && c <= 20) ? 1 : 0);
      tick();
    end
    barrier_clear = 1'b0;
    check("bar_pfb_idle", all_pfb, 0);

    // Empty mask never satisfies; clear vs set in the same cycle
    quad_enable = '0; pip = 4'b1111; pfb = 4'b1111;
    tick(); tick();
    check("mask0", {all_pip, all_pfb}, 2'b00);
    quad_enable = 4'b1111;
    tick();
    check("mask_set", {all_pip, all_pfb}, 2'b11);
    barrier_clear = 1'b1;
    tick();
    check("clr_wins", {all_pip, all_pfb}, 2'b00);
    barrier_clear = 1'b0; pfb = '0;
    tick();
    check("reassert", {all_pip, all_pfb}, 2'b10);
    pip = '0; barrier_clear = 1'b1;
    tick();
    barrier_clear = 1'b0;

    // Asynchronous reset with link levels 5 and 3
    cir = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      cov[0] = 1'b1; cov[1] = (k < 3);
      cod[15:0] = 16'(300 + k); cod[31:16] = 16'(400 + k);
      tick();
    end
    cov = '0;
    check("pre_rst_levels", link_level[7:0], 8'h35);
    check("pre_rst_civ", civ[3:1], 3'b011);
    #2 rst = 1'b0;
    #1;
    check("async_levels", link_level, 0);
    check("async_civ", civ[3:1], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Flush beats a same-cycle push
    cov[0] = 1'b1; cod[15:0] = 16'h55;
    tick(); tick();
    check("pre_flush", link_level[3:0], 2);
    flush = 1'b1; cod[15:0] = 16'h66;
    tick();
    check("flush_level", link_level[3:0], 0);
    check("flush_civ", civ[1], 0);
    flush = 1'b0; cov = '0;
    tick();
    check("flush_lost", {link_level, 3'(civ[3:1])}, 0);
    cir = 4'b1111;
    tick();
    check("end_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
